// File: rtl/diff_window_capture.sv
// diff_window_capture: stores |cur - prev| for every pixel of an armed WIN x WIN
// window and presents the finished window as a flat bus with a valid/ack handshake.
module diff_window_capture #(
    parameter int WIN      = 11,
    parameter int PIX_W    = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start_i,
    input  logic                       pix_valid_i,
    input  logic [9:0]                 pix_x_i,
    input  logic [9:0]                 pix_y_i,
    input  logic [PIX_W-1:0]           cur_pix_i,
    input  logic [PIX_W-1:0]           prev_pix_i,
    input  logic                       arm_i,
    input  logic [9:0]                 org_x_i,
    input  logic [9:0]                 org_y_i,
    input  logic                       window_ack_i,
    output logic                       window_valid_o,
    output logic [WIN*WIN*PIX_W-1:0]   diff_flat_o,
    output logic                       busy_o,
    output logic                       org_err_o,
    output logic [6:0]                 capt_cnt_o
);

    // state    | meaning
    // IDLE     | no capture requested
    // WAIT_SOF | origin latched, waiting for frame_start
    // CAPTURE  | storing in-window differences
    // HOLD     | window complete, waiting for window_ack
    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, HOLD} state_t;

    localparam int N     = WIN * WIN;
    localparam int IDX_W = $clog2(N);

    state_t           state_q, state_d;
    logic [9:0]       ox_q, ox_d, oy_q, oy_d;
    logic [6:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [PIX_W-1:0] diff_q [N];

    logic [10:0]      rel_x, rel_y;
    logic             org_ok, in_win, corner, wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [PIX_W-1:0] abs_diff;

    assign org_ok = ({1'b0, org_x_i} + 11'(WIN) <= 11'(H_ACTIVE)) &&
                    ({1'b0, org_y_i} + 11'(WIN) <= 11'(V_ACTIVE));

    // Unsigned 11-bit offsets: beats left of / above the origin wrap to large values.
    assign rel_x    = {1'b0, pix_x_i} - {1'b0, ox_q};
    assign rel_y    = {1'b0, pix_y_i} - {1'b0, oy_q};
    assign in_win   = pix_valid_i && (rel_x < 11'(WIN)) && (rel_y < 11'(WIN));
    assign corner   = (rel_x == 11'(WIN - 1)) && (rel_y == 11'(WIN - 1));
    assign wr_idx   = IDX_W'(32'(rel_y) * WIN + 32'(rel_x));
    assign abs_diff = (cur_pix_i >= prev_pix_i) ? (cur_pix_i - prev_pix_i)
                                                : (prev_pix_i - cur_pix_i);

    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm_i) begin
                    if (org_ok) begin
                        ox_d    = org_x_i;
                        oy_d    = org_y_i;
                        state_d = WAIT_SOF;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_SOF: begin
                if (frame_start_i) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end
            end
            CAPTURE: begin
                if (frame_start_i) begin
                    cnt_d = '0;
                end else if (in_win) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 7'd1;
                    if (corner) state_d = HOLD;
                end
            end
            HOLD: begin
                if (window_ack_i) begin
                    state_d = IDLE;
                    if (arm_i) begin
                        if (org_ok) begin
                            ox_d    = org_x_i;
                            oy_d    = org_y_i;
                            state_d = WAIT_SOF;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) diff_q[i] <= '0;
        end else if (wr_en) begin
            diff_q[wr_idx] <= abs_diff;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign diff_flat_o[g*PIX_W +: PIX_W] = diff_q[g];
    end

    assign window_valid_o = (state_q == HOLD);
    assign busy_o         = (state_q == WAIT_SOF) || (state_q == CAPTURE);
    assign org_err_o      = err_q;
    assign capt_cnt_o     = cnt_q;

endmodule

// File: tb/tb_diff_window_capture.sv
// Bench for diff_window_capture: directed scenarios plus randomized frames, checked
// every cycle against a coordinate-level model of the capture rules.
module tb_diff_window_capture;

    localparam int WIN = 11;
    localparam int PIX_W = 8;
    localparam int H = 640;
    localparam int V = 480;
    localparam int N = WIN * WIN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0, pix_valid = 1'b0, arm = 1'b0, window_ack = 1'b0;
    logic [9:0] pix_x = '0, pix_y = '0, org_x = '0, org_y = '0;
    logic [PIX_W-1:0] cur_pix = '0, prev_pix = '0;
    logic window_valid, busy, org_err;
    logic [N*PIX_W-1:0] diff_flat;
    logic [6:0] capt_cnt;

    diff_window_capture #(.WIN(WIN), .PIX_W(PIX_W), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst(rst), .frame_start_i(frame_start), .pix_valid_i(pix_valid),
        .pix_x_i(pix_x), .pix_y_i(pix_y), .cur_pix_i(cur_pix), .prev_pix_i(prev_pix),
        .arm_i(arm), .org_x_i(org_x), .org_y_i(org_y), .window_ack_i(window_ack),
        .window_valid_o(window_valid), .diff_flat_o(diff_flat), .busy_o(busy),
        .org_err_o(org_err), .capt_cnt_o(capt_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int elem(input int i);
        return int'(diff_flat[i*PIX_W +: PIX_W]);
    endfunction

    // Model: mode 0 idle, 1 waiting for frame, 2 capturing, 3 window held
    int m_mode = 0, m_ox = 0, m_oy = 0, m_cnt = 0;
    bit m_err = 0;
    int m_win [N];

    function automatic bit origin_fits(input int x, input int y);
        return (x + WIN <= H) && (y + WIN <= V);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_mode = 0; m_ox = 0; m_oy = 0; m_cnt = 0; m_err = 0;
            foreach (m_win[i]) m_win[i] = 0;
        end else begin
            bit want_arm;
            want_arm = 0;
            m_err = 0;
            if (m_mode == 0) want_arm = arm;
            else if (m_mode == 1 && frame_start) begin
                m_mode = 2; m_cnt = 0;
            end else if (m_mode == 2) begin
                if (frame_start) m_cnt = 0;
                else if (pix_valid && int'(pix_x) >= m_ox && int'(pix_x) < m_ox + WIN &&
                         int'(pix_y) >= m_oy && int'(pix_y) < m_oy + WIN) begin
                    int d;
                    d = int'(cur_pix) - int'(prev_pix);
                    m_win[(int'(pix_y) - m_oy) * WIN + int'(pix_x) - m_ox] = (d < 0) ? -d : d;
                    m_cnt = (m_cnt + 1) % 128;
                    if (int'(pix_x) == m_ox + WIN - 1 && int'(pix_y) == m_oy + WIN - 1) m_mode = 3;
                end
            end else if (m_mode == 3 && window_ack) begin
                m_mode = 0;
                want_arm = arm;
            end
            if (want_arm) begin
                if (origin_fits(int'(org_x), int'(org_y))) begin
                    m_ox = int'(org_x); m_oy = int'(org_y); m_mode = 1;
                end else m_err = 1;
            end
        end
    end

    int bad;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("window_valid", int'(window_valid), int'(m_mode == 3));
            chk("busy", int'(busy), int'(m_mode == 1 || m_mode == 2));
            chk("org_err", int'(org_err), int'(m_err));
            chk("capt_cnt", int'(capt_cnt), m_cnt);
            bad = -1;
            for (int i = 0; i < N; i++)
                if (bad < 0 && elem(i) != m_win[i]) bad = i;
            n_checks++;
            if (bad >= 0) begin
                n_errors++;
                $display("FAIL diff_flat elem %0d: got %0d expected %0d", bad, elem(bad), m_win[bad]);
            end
            if (!prev_valid && window_valid) rise_cyc = cyc;
            prev_valid = window_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int x, input int y);
        arm = 1; org_x = 10'(x); org_y = 10'(y);
        tick();
        arm = 0;
    endtask

    task automatic do_ack(input bit a, input int x, input int y);
        window_ack = 1; arm = a; org_x = 10'(x); org_y = 10'(y);
        tick();
        window_ack = 0; arm = 0;
    endtask

    task automatic pulse_fs();
        frame_start = 1;
        tick();
        frame_start = 0;
    endtask

    int corner_cyc = -1;

    // Sends a sub-raster covering the window around (ox,oy); stops after max_inwin
    // in-window beats when max_inwin >= 0. mode picks the pixel pattern.
    task automatic send_frame(input int ox, input int oy, input int mode,
                              input int max_inwin, input bit noise);
        int x0, x1, y0, y1, n, c, p;
        bit inw;
        x0 = (ox > 2) ? ox - 2 : 0;
        y0 = (oy > 2) ? oy - 2 : 0;
        x1 = (ox + WIN + 1 < H) ? ox + WIN + 1 : H - 1;
        y1 = (oy + WIN + 1 < V) ? oy + WIN + 1 : V - 1;
        n = 0;
        pulse_fs();
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                if (max_inwin >= 0 && n >= max_inwin) return;
                case (mode)
                    0: begin p = $urandom_range(0, 252); c = p + 3; end
                    1: begin
                        if (x == 105 && y == 52) begin c = 77; p = 7; end
                        else begin c = 10; p = 200; end
                    end
                    3: begin c = (x + 3 * y + 50) % 256; p = 20; end
                    default: begin c = $urandom_range(0, 255); p = $urandom_range(0, 255); end
                endcase
                inw = (x >= ox && x < ox + WIN && y >= oy && y < oy + WIN);
                if (inw) n++;
                if (inw && x == ox + WIN - 1 && y == oy + WIN - 1) corner_cyc = cyc;
                pix_valid = 1; pix_x = 10'(x); pix_y = 10'(y);
                cur_pix = 8'(c); prev_pix = 8'(p);
                if (noise) begin
                    window_ack = ($urandom_range(0, 19) == 0);
                    arm = ($urandom_range(0, 19) == 0);
                    org_x = 10'($urandom_range(0, 700));
                    org_y = 10'($urandom_range(0, 500));
                end
                tick();
                pix_valid = 0; window_ack = 0; arm = 0;
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
    endtask

    initial begin
        int nbad;
        repeat (3) tick();
        rst = 0;
        chk_en = 1;
        chk("rst_valid", int'(window_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_org_err", int'(org_err), 0);
        chk("rst_capt_cnt", int'(capt_cnt), 0);
        chk("rst_diff_zero", int'(diff_flat == '0), 1);

        // Constant offset of 3 across the window
        do_arm(100, 50);
        chk("t1_busy_after_arm", int'(busy), 1);
        rise_cyc = -1;
        send_frame(100, 50, 0, -1, 0);
        nbad = 0;
        for (int i = 0; i < N; i++) if (elem(i) != 3) nbad++;
        chk("t1_elems_not_3", nbad, 0);
        chk("t1_capt_cnt", int'(capt_cnt), 121);
        chk("t1_valid", int'(window_valid), 1);
        chk("t1_valid_latency", rise_cyc - corner_cyc, 1);
        do_ack(0, 0, 0);
        chk("t1_valid_after_ack", int'(window_valid), 0);

        // Single odd pixel inside a uniform field
        do_arm(100, 50);
        send_frame(100, 50, 1, -1, 0);
        chk("t2_elem27", elem(27), 70);
        chk("t2_elem0", elem(0), 190);
        chk("t2_elem120", elem(120), 190);
        do_ack(0, 0, 0);

        // Origin range boundaries
        do_arm(635, 0);
        chk("t3_org_err_pulse", int'(org_err), 1);
        chk("t3_busy_rejected", int'(busy), 0);
        tick();
        chk("t3_org_err_clear", int'(org_err), 0);
        do_arm(629, 469);
        chk("t3_edge_accept_busy", int'(busy), 1);
        chk("t3_edge_no_err", int'(org_err), 0);
        send_frame(629, 469, 2, -1, 0);
        chk("t3_edge_valid", int'(window_valid), 1);

        // Mid-capture frame_start restart, then ack+arm re-arm from HOLD
        do_ack(1, 100, 50);
        chk("t4_rearm_busy", int'(busy), 1);
        send_frame(100, 50, 2, 40, 0);
        chk("t4_cnt_40", int'(capt_cnt), 40);
        pulse_fs();
        chk("t4_cnt_restart", int'(capt_cnt), 0);
        send_frame(100, 50, 2, -1, 0);
        chk("t4_valid", int'(window_valid), 1);
        chk("t4_cnt_121", int'(capt_cnt), 121);
        do_ack(1, 0, 0);
        chk("t4_valid_drop", int'(window_valid), 0);
        chk("t4_wait_sof_busy", int'(busy), 1);
        send_frame(0, 0, 3, -1, 0);
        chk("t4_elem00", elem(0), 30);
        do_ack(0, 0, 0);

        // Reset mid-capture
        do_arm(200, 100);
        send_frame(200, 100, 2, 60, 0);
        chk("t5_cnt_60", int'(capt_cnt), 60);
        rst = 1;
        tick();
        rst = 0;
        chk("t5_cnt_zero", int'(capt_cnt), 0);
        chk("t5_busy_zero", int'(busy), 0);
        chk("t5_diff_zero", int'(diff_flat == '0), 1);
        send_frame(200, 100, 2, -1, 0);
        chk("t5_no_arm_valid", int'(window_valid), 0);
        chk("t5_no_arm_diff", int'(diff_flat == '0), 1);

        // Randomized sequences
        for (int it = 0; it < 40; it++) begin
            int ox, oy, sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin ox = $urandom_range(630, 1023); oy = $urandom_range(0, 469); end
            else if (sel == 1) begin ox = $urandom_range(0, 629); oy = $urandom_range(470, 1023); end
            else if (sel == 2) begin ox = 629; oy = 469; end
            else begin ox = $urandom_range(0, 629); oy = $urandom_range(0, 469); end
            if (m_mode == 3) do_ack(1, ox, oy);
            else if (m_mode == 0) do_arm(ox, oy);
            if ($urandom_range(0, 4) == 0) send_frame(ox, oy, 2, $urandom_range(0, 100), 1);
            send_frame(ox, oy, 2, -1, 1);
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 9) == 0) begin rst = 1; tick(); rst = 0; end
            if ($urandom_range(0, 1) == 1) do_ack(0, 0, 0);
        end

        tick();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/diff_window_capture.md
Name: diff_window_capture

Overview:
- Producer side of the 11x11 pixel-difference window consumed by the window-sum block in the motion-detect path.
- Watches the raster pixel stream, which carries current-frame and previous-frame 8-bit grey samples side by side.
- Computes |cur - prev| for every pixel inside an armed window and stores the results in a register window.
- Presents the complete window as a flattened bus with a valid/ack handshake, one window per armed request.

Parameters:
WIN, 11, window edge length in pixels (window holds WIN*WIN elements)
PIX_W, 8, grey sample width
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
frame_start  in  1  one-cycle pulse before the first pixel of a frame
pix_valid  in  1  pixel beat qualifier
pix_x  in  10  column of current beat
pix_y  in  10  row of current beat
cur_pix  in  PIX_W  current-frame grey sample
prev_pix  in  PIX_W  previous-frame grey sample, same coordinate
arm  in  1  capture request pulse
org_x  in  10  window top-left column, sampled on accepted arm
org_y  in  10  window top-left row, sampled on accepted arm
window_ack  in  1  consumer has taken the window
window_valid  out  1  diff_flat holds a complete window
diff_flat  out  WIN*WIN*PIX_W  element (r,c) at bits [(r*WIN+c)*PIX_W +: PIX_W]
busy  out  1  high in WAIT_SOF and CAPTURE
org_err  out  1  one-cycle pulse: arm rejected, origin out of range
capt_cnt  out  7  in-window beats accepted this capture (debug)

Behaviour:
- Reset: state IDLE; all outputs 0; every diff_flat element 0; latched origin 0.
- States: IDLE, WAIT_SOF, CAPTURE, HOLD.
- IDLE, arm=1:
  - If org_x+WIN > H_ACTIVE or org_y+WIN > V_ACTIVE: org_err=1 for the next cycle, stay IDLE.
  - Otherwise latch org_x/org_y and go to WAIT_SOF.
- arm is ignored in WAIT_SOF and CAPTURE. In HOLD it counts only together with window_ack (see HOLD).
- WAIT_SOF: frame_start moves to CAPTURE and clears capt_cnt. Pixel beats before frame_start are ignored.
- CAPTURE:
  - A beat is in-window when pix_valid=1, ox <= pix_x < ox+WIN and oy <= pix_y < oy+WIN.
  - Each in-window beat registers |cur_pix - prev_pix| (unsigned, PIX_W bits, no saturation needed) into element r=pix_y-oy, c=pix_x-ox.
  - Each in-window beat increments capt_cnt.
  - A repeated coordinate overwrites its element.
- Completion: the in-window beat at (ox+WIN-1, oy+WIN-1) writes its element and moves to HOLD. window_valid=1 on the following cycle, so latency is 1 clock after that beat.
- frame_start during CAPTURE: the partial window is discarded, capture restarts (capt_cnt=0), and stale elements are overwritten as the new frame arrives.
- HOLD:
  - window_valid=1; diff_flat and capt_cnt stay stable; pixel beats are ignored.
  - window_ack=1 with arm=0: go to IDLE; window_valid=0 next cycle.
  - window_ack=1 with arm=1: origin check as in IDLE. Pass: latch the new origin and go to WAIT_SOF. Fail: org_err pulse and go to IDLE. window_valid=0 next cycle in every case.
- diff_flat keeps its last values after ack until they are overwritten by a later capture.
- window_ack outside HOLD is ignored.
- rst asserted in any state, including mid-capture, returns everything to reset values on the next edge.

Test Plan:
- Reset -> window_valid=0, busy=0, org_err=0, capt_cnt=0, diff_flat all 0.
- arm with org=(100,50), then a full frame with cur=prev+3 everywhere -> busy=1 from the cycle after arm; all 121 elements = 3; capt_cnt=121; window_valid rises 1 cycle after beat (110,60); out-of-window beats leave nothing changed.
- Same origin, cur=10/prev=200 everywhere except pixel (105,52) with cur=77/prev=7 -> element index 27 (r=2, c=5) = 70, all others = 190.
- arm with org_x=635 -> org_err high exactly 1 cycle, state stays IDLE, busy=0. Repeat with org_x=629, org_y=469 -> accepted, busy=1.
- frame_start injected after 40 in-window beats -> capt_cnt returns to 0, capture completes on the next frame's (110,60) beat. Then window_ack+arm with origin (0,0) in HOLD -> window_valid drops next cycle and state is WAIT_SOF; the next frame captures element (0,0) from pixel (0,0).
- rst pulsed mid-capture (capt_cnt=60) -> all outputs and diff_flat return to 0, state IDLE; subsequent frames with no arm capture nothing.
